tx_byte_serializer: RTL and testbench
=====================================

Name: tx_byte_serializer

Overview:
- Output-side transmitter inside Top. Produces the byte stream that the Top bench captures on o_data/o_valid.
- Accepts the finished 128-bit AES cipher block and 256-bit HMAC-SHA3 value from the crypto cores.
- Sends them as two separate byte-serial frames on o_data while o_valid is high: cipher frame first, then MAC frame.
- Frames are separated by o_valid low, so a downstream rising-edge detector sees exactly two frames per pattern.

Parameters:
- CIPHER_BYTES, 16, cipher frame length in bytes.
- MAC_BYTES, 32, MAC frame length in bytes.
- GAP_CYCLES, 1, idle cycles with o_valid=0 between the two frames. Legal range 1..15.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_cipher  input  CIPHER_BYTES*8  cipher block; byte k is bits [8k+7:8k].
- i_cipher_valid  input  1  cipher block available.
- o_cipher_ready  output  1  cipher accepted on a cycle where valid&ready.
- i_mac  input  MAC_BYTES*8  HMAC value; byte k is bits [8k+7:8k].
- i_mac_valid  input  1  MAC value available.
- o_mac_ready  output  1  MAC accepted on a cycle where valid&ready.
- o_data  output  8  serial byte.
- o_valid  output  1  o_data holds a frame byte.
- o_busy  output  1  high from cipher accept until the last MAC byte.
- o_done  output  1  one-cycle pulse after the last MAC byte.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; o_data=8'h00; o_valid=0; o_busy=0; o_done=0; o_mac_ready=0; o_cipher_ready=1 after reset.
  - Both buffers empty; byte counter=0.
  - Reset mid-frame aborts the transfer; o_valid=0 from the next cycle; partial frame discarded.
- All outputs are registered. o_data=8'h00 whenever o_valid=0.
- Ready signals:
  - o_cipher_ready=1 only in IDLE.
  - o_mac_ready=1 only when state is not IDLE and the MAC buffer is empty.
  - i_mac_valid in IDLE is ignored, so ordering is enforced: cipher always precedes MAC.
- IDLE:
  - On i_cipher_valid, latch i_cipher into the cipher shift register and go to SEND_C.
  - First byte appears on o_data with o_valid=1 in the cycle after the accept. Latency is 1 cycle.
- SEND_C:
  - Emits CIPHER_BYTES consecutive bytes with no bubbles, byte 0 (bits [7:0]) first.
  - Shift register moves right 8 bits per cycle.
  - After the last byte, go to GAP.
- GAP:
  - o_valid=0 for exactly GAP_CYCLES cycles.
  - Then go to SEND_M if the MAC buffer is full, else WAIT_M.
- WAIT_M:
  - o_valid=0. On a MAC accept, go to SEND_M; first MAC byte appears the next cycle.
- MAC accept timing: a MAC accepted during SEND_C or GAP is buffered. It must not disturb the cipher frame or shorten the gap.
- SEND_M:
  - Emits MAC_BYTES bytes, byte 0 first, with no bubbles.
  - After the last byte: go to IDLE, o_done=1 for one cycle, o_busy=0, o_valid=0, both buffers cleared.
- A cipher accept is possible on the cycle o_done is high, which allows back-to-back patterns.
  - o_valid stays low for at least that one cycle, so every frame starts with a rising edge.
- Byte counter is 6 bits and never wraps past the frame length. There is no backpressure from the output side.

Optional Feature:
- Macro TXSER_MSB_FIRST_EN.
- Defined: both frames are sent most-significant byte first. Cipher bits [8*CIPHER_BYTES-1 -:8] go first; shift registers move left.
- Undefined: least-significant byte first, as described above.
- Timing and handshakes are identical in both builds.

Test Plan:
- Basic order: rst 2 cycles, then i_cipher=128'h00112233445566778899aabbccddeeff with valid 1 cycle, then MAC held valid.
  - Expect cipher frame ff,ee,dd,...,11,00 over 16 cycles.
  - Then exactly 1 cycle of o_valid=0.
  - Then MAC frame starting with i_mac[7:0], 32 cycles, then o_done pulse.
- Late MAC: i_mac_valid asserted 20 cycles after the cipher frame ends.
  - Expect o_valid=0 throughout WAIT_M.
  - Expect o_mac_ready=1 during the wait and the first MAC byte 1 cycle after the accept.
- Early MAC in IDLE: i_mac_valid=1 before any cipher.
  - Expect o_mac_ready=0 and no output.
  - After the cipher accept, the MAC is taken during SEND_C and sent after the gap.
- Reset mid-frame: rst high at cipher byte 7.
  - Expect o_valid=0 and o_data=00 next cycle, o_cipher_ready=1.
  - A new cipher then transmits fully from byte 0.
- Back-to-back: 20 patterns with the next cipher valid on the o_done cycle.
  - Expect 40 frames, each preceded by o_valid low.
  - Expect 16/32 byte counts to match the golden data.
- TXSER_MSB_FIRST_EN build: same vector as the basic-order case.
  - Expect cipher frame 00,11,22,...,ff, with identical cycle timing.

Source files
------------

// File: rtl/tx_byte_serializer.sv
// tx_byte_serializer: sends a cipher frame then a MAC frame byte-serially; `define TXSER_MSB_FIRST_EN for most-significant-byte-first order
module tx_byte_serializer #(
  parameter int CIPHER_BYTES = 16,
  parameter int MAC_BYTES = 32,
  parameter int GAP_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CIPHER_BYTES*8-1:0] i_cipher,
  input  logic                      i_cipher_valid,
  output logic                      o_cipher_ready,
  input  logic [MAC_BYTES*8-1:0]    i_mac,
  input  logic                      i_mac_valid,
  output logic                      o_mac_ready,
  output logic [7:0]                o_data,
  output logic                      o_valid,
  output logic                      o_busy,
  output logic                      o_done
);
  localparam int CW = CIPHER_BYTES * 8;
  localparam int MW = MAC_BYTES * 8;
  localparam logic [2:0] IDLE = 3'd0, SEND_C = 3'd1, GAP = 3'd2, WAIT_M = 3'd3, SEND_M = 3'd4;
`ifdef TXSER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif
  logic [2:0] state, state_n;
  logic [CW-1:0] c_sr, c_sr_n, c_src;
  logic [MW-1:0] m_sr, m_sr_n, m_src;
  logic m_full, m_full_n;
  logic [5:0] cnt, cnt_n;
  logic [7:0] data_n;
  logic valid_n, done_n;
  logic c_acc, m_acc, m_have, c_last, g_last, m_last;
  assign c_acc = i_cipher_valid & o_cipher_ready;
  assign m_acc = i_mac_valid & o_mac_ready;
  assign m_have = m_full | m_acc;
  assign c_src = (state == IDLE) ? i_cipher : c_sr;
  assign m_src = m_full ? m_sr : i_mac;
  assign c_last = cnt == 6'(CIPHER_BYTES - 1);
  assign g_last = cnt == 6'(GAP_CYCLES - 1);
  assign m_last = cnt == 6'(MAC_BYTES - 1);
  always_comb begin
    state_n = state;
    c_sr_n = c_sr;
    m_sr_n = m_acc ? i_mac : m_sr;
    m_full_n = m_have;
    cnt_n = cnt;
    data_n = 8'h00;
    valid_n = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = c_acc ? SEND_C : IDLE;
        cnt_n = 6'd0;
        valid_n = c_acc;
      end
      SEND_C: begin
        state_n = c_last ? GAP : SEND_C;
        cnt_n = c_last ? 6'd0 : cnt + 6'd1;
        valid_n = !c_last;
      end
      GAP: begin
        state_n = !g_last ? GAP : m_have ? SEND_M : WAIT_M;
        cnt_n = g_last ? 6'd0 : cnt + 6'd1;
        valid_n = g_last & m_have;
      end
      WAIT_M: begin
        state_n = m_acc ? SEND_M : WAIT_M;
        valid_n = m_acc;
      end
      SEND_M: begin
        state_n = m_last ? IDLE : SEND_M;
        cnt_n = m_last ? 6'd0 : cnt + 6'd1;
        valid_n = !m_last;
        done_n = m_last;
        m_full_n = !m_last;
      end
      default: state_n = IDLE;
    endcase
    if (valid_n && state_n == SEND_C) begin
      data_n = MSB_FIRST ? c_src[CW-1 -: 8] : c_src[7:0];
      c_sr_n = MSB_FIRST ? c_src << 8 : c_src >> 8;
    end
    if (valid_n && state_n == SEND_M) begin
      data_n = MSB_FIRST ? m_src[MW-1 -: 8] : m_src[7:0];
      m_sr_n = MSB_FIRST ? m_src << 8 : m_src >> 8;
    end
    if (state_n == IDLE) begin
      c_sr_n = '0;
      m_sr_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c_sr <= '0;
      m_sr <= '0;
      m_full <= 1'b0;
      cnt <= 6'd0;
      o_data <= 8'h00;
      o_valid <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_cipher_ready <= 1'b1;
      o_mac_ready <= 1'b0;
    end else begin
      state <= state_n;
      c_sr <= c_sr_n;
      m_sr <= m_sr_n;
      m_full <= m_full_n;
      cnt <= cnt_n;
      o_data <= data_n;
      o_valid <= valid_n;
      o_busy <= state_n != IDLE;
      o_done <= done_n;
      o_cipher_ready <= state_n == IDLE;
      o_mac_ready <= (state_n != IDLE) && !m_full_n;
    end
  end
endmodule

// File: tb/tb_tx_byte_serializer.sv
// tb_tx_byte_serializer: scoreboard bench for tx_byte_serializer frame order, gaps, handshakes and reset abort
module tb_tx_byte_serializer;
  localparam int CB = 16;
  localparam int MB = 32;
  localparam int GAPC = 1;
  localparam int CW = CB * 8;
  localparam int MW = MB * 8;
`ifdef TXSER_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif
  typedef struct {logic [7:0] d; int low; bit last;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] i_cipher = '0;
  logic i_cipher_valid = 1'b0;
  logic o_cipher_ready;
  logic [MW-1:0] i_mac = '0;
  logic i_mac_valid = 1'b0;
  logic o_mac_ready;
  logic [7:0] o_data;
  logic o_valid, o_busy, o_done;
  exp_t q[$];
  int checks = 0;
  int fails = 0;
  int low_cnt = 99;
  int done_seen = 0;
  bit done_exp = 1'b0;
  bit mon_en = 1'b1;
  localparam logic [CW-1:0] BASIC = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  tx_byte_serializer #(.CIPHER_BYTES(CB), .MAC_BYTES(MB), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst(rst),
    .i_cipher(i_cipher), .i_cipher_valid(i_cipher_valid), .o_cipher_ready(o_cipher_ready),
    .i_mac(i_mac), .i_mac_valid(i_mac_valid), .o_mac_ready(o_mac_ready),
    .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [CW-1:0] mkc(input int s);
    logic [CW-1:0] r;
    for (int j = 0; j < CB; j++) r[8*j +: 8] = 8'(s * 37 + j * 11 + 5);
    return r;
  endfunction

  function automatic logic [MW-1:0] mkm(input int s);
    logic [MW-1:0] r;
    for (int j = 0; j < MB; j++) r[8*j +: 8] = 8'(s * 29 + j * 7 + 3);
    return r;
  endfunction

  task automatic push_frame(input logic [MW-1:0] v, input int n, input int low);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.d = MSB ? v[8*(n-1-k) +: 8] : v[8*k +: 8];
      e.low = (k == 0) ? low : 0;
      e.last = (n == MB) && (k == n - 1);
      q.push_back(e);
    end
  endtask

  task automatic send_cipher(input logic [CW-1:0] c, input int low);
    int t = 0;
    i_cipher = c;
    i_cipher_valid = 1'b1;
    while (!o_cipher_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!o_cipher_ready) chk("cipher_accept_timeout", 0, 1);
    else push_frame(MW'(c), CB, low);
    @(posedge clk);
    #1;
    i_cipher_valid = 1'b0;
    @(negedge clk);
    chk("cipher_latency", o_valid, 1);
  endtask

  task automatic send_mac(input logic [MW-1:0] m, input int low, input bit lat);
    int t = 0;
    i_mac = m;
    i_mac_valid = 1'b1;
    while (!o_mac_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!o_mac_ready) chk("mac_accept_timeout", 0, 1);
    else push_frame(m, MB, low);
    @(posedge clk);
    #1;
    i_mac_valid = 1'b0;
    if (lat) begin
      @(negedge clk);
      chk("mac_latency", o_valid, 1);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      low_cnt = 99;
      done_exp = 1'b0;
    end else if (mon_en) begin
      chk("done_pulse", o_done, done_exp);
      if (o_done) done_seen++;
      done_exp = 1'b0;
      if (o_valid) begin
        if (q.size() == 0) chk("unexpected_byte", o_data, 0);
        else begin
          e = q.pop_front();
          chk("byte", o_data, e.d);
          chk("low_before", (e.low < 0) ? (low_cnt >= 1) : (low_cnt == e.low), 1);
          done_exp = e.last;
        end
        low_cnt = 0;
      end else begin
        chk("idle_data", o_data, 0);
        low_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cipher_ready", o_cipher_ready, 1);
    chk("rst_mac_ready", o_mac_ready, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    rst = 1'b0;
    @(negedge clk);
    fork
      send_cipher(BASIC, -1);
      send_mac(mkm(100), GAPC, 1'b0);
    join
    drain();
    send_cipher(mkc(1), -1);
    repeat (CB - 1) @(negedge clk);
    bad = 1'b0;
    repeat (GAPC + 20) begin
      @(negedge clk);
      bad |= o_valid | !o_mac_ready | !o_busy;
    end
    chk("wait_m_idle", bad, 0);
    send_mac(mkm(1), -1, 1'b1);
    drain();
    i_mac = mkm(2);
    i_mac_valid = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      bad |= o_mac_ready | o_valid;
    end
    chk("idle_mac_ignored", bad, 0);
    fork
      send_cipher(mkc(2), -1);
      send_mac(mkm(2), GAPC, 1'b0);
    join
    drain();
    mon_en = 1'b0;
    i_cipher = BASIC;
    i_cipher_valid = 1'b1;
    @(posedge clk);
    #1;
    i_cipher_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_byte7", o_data, MSB ? 8'h77 : 8'h88);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", o_valid, 0);
    chk("abort_data", o_data, 0);
    chk("abort_cipher_ready", o_cipher_ready, 1);
    chk("abort_busy", o_busy, 0);
    rst = 1'b0;
    low_cnt = 99;
    done_exp = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    fork
      send_cipher(BASIC, -1);
      send_mac(mkm(3), GAPC, 1'b0);
    join
    drain();
    for (int k = 0; k < 20; k++) begin
      fork
        send_cipher(mkc(10 + k), (k == 0) ? -1 : 1);
        send_mac(mkm(10 + k), GAPC, 1'b0);
      join
    end
    drain();
    chk("done_count", done_seen, 24);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
